mult_sched: RTL and testbench
=============================

Name: mult_sched

Overview:
- Round-robin scheduler that shares one clocked shift-add multiplier between N requesters.
- Arbitrates requests, captures the winner's operands, and sequences W iteration cycles.
- Returns the full 2W-bit product on a shared result bus, tagged with the requester ID.
- Sits between the ALU-side requesters and the multiply datapath, replacing the start-edge-triggered multiplier with a synchronous, handshaked unit.

Parameters:
- W, 16, operand width in bits.
- N, 2, number of requesters (N >= 2).
- IDW, 1, requester ID width; must equal clog2(N).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N  per-requester request; held high until the matching ack.
- a_in  in  N*W  packed multiplicands; slice i = a_in[i*W +: W].
- b_in  in  N*W  packed multipliers, same packing as a_in.
- ack  out  N  one-cycle grant pulse; operands were captured on that edge.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle result-valid pulse.
- done_id  out  IDW  requester index of the current result; valid when done=1.
- prod  out  2W  unsigned product a*b; held until the next done.

Behaviour:
- Reset (async, immediate): state=IDLE, ack=0, done=0, done_id=0, prod=0, rr_ptr=0, count=0, internal registers=0. Reset mid-RUN aborts the operation; no done is ever produced for it.
- States: IDLE, RUN, DONE.
- IDLE, when any req is high:
  - Winner = first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ... mod N.
  - On the clock edge: ack[winner]=1 for exactly one cycle; A <= a slice; P <= {W'b0, b slice}; cur_id <= winner; count <= W-1.
  - If the a or b slice is zero: go to DONE, with P forced to 0. Otherwise go to RUN.
  - With no req, stay in IDLE; all outputs hold.
- RUN, one iteration per cycle:
  - sum[W:0] = P[2W-1:W] + (P[0] ? A : 0), computed at W+1 bits to keep the carry.
  - P <= {sum, P[W-1:1]}.
  - count decrements each cycle. On the edge where count==0, go to DONE.
  - Exactly W RUN cycles. After them P == A*B exactly, with no truncation.
- DONE (one cycle):
  - done=1, done_id=cur_id, prod=P, registered, so all are valid during this cycle.
  - rr_ptr <= (cur_id+1) mod N.
  - Next state IDLE; new requests are not arbitrated during DONE.
- Latency:
  - done rises W+1 cycles after the ack cycle (ack at cycle 0, done at cycle W+1).
  - Zero-operand shortcut: done at cycle 1.
  - Back-to-back throughput: one result per W+2 cycles.
- Requester rules:
  - A req still high in the cycle after its ack counts as a new request.
  - Requesters must drop req in the ack cycle unless they want another operation.
  - Operands may change freely after ack.
- Simultaneous requests: exactly one ack per arbitration. Losers stay pending, and a persistent requester is served within N arbitrations (no starvation).
- A req deasserted before ack is simply not served; there is no error.
- ack, done and done_id are never X after reset; ack is one-hot or zero.

Decomposition:
- Shared package mult_pkg:
  - state enum {IDLE, RUN, DONE};
  - localparam MULT_W=16;
  - function clog2 for IDW checks.
- Sub-module mult_dp, the datapath:
  - registers A and P, the adder and the shifter;
  - controls: load, zero, step;
  - output: P.
- mult_sched keeps the FSM, counter, round-robin pointer and output registers.

Test Plan:
- Single request: req[0] with a=3, b=5 -> ack[0] pulse at cycle 0; done at cycle 17; done_id=0; prod=0x0000000F; busy high for cycles 0-16.
- Maximum operands: a=0xFFFF, b=0xFFFF on req[1] -> prod=0xFFFE0001, done_id=1.
- Zero shortcut: a=0x1234, b=0 -> done at cycle 1, prod=0.
- Contention: req[0] and req[1] held together from reset (a0=2, b0=7, a1=9, b1=9) -> grants in order 0 then 1; results 0x0E (id 0) then 0x51 (id 1); with both still held, the next grant goes to 0.
- Mid-operation reset: start 0x00FF*0x0101, assert rst at cycle 8 -> all outputs 0 immediately; no done pulse; a fresh 6*7 after release -> prod=0x2A.
- Late operand change: change a_in/b_in in the cycle after ack -> result reflects the captured values only.

Source files
------------

// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM type, default operand width and elaboration helpers.
package mult_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int MULT_W = 16;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/mult_sched_if.sv
// mult_sched_if: requester handshake and shared, ID-tagged result bus.
interface mult_sched_if import mult_pkg::*; #(parameter int W = MULT_W, parameter int N = 2, parameter int IDW = 1);
  logic [N-1:0]   req;
  logic [N*W-1:0] a_in;
  logic [N*W-1:0] b_in;
  logic [N-1:0]   ack;
  logic           busy;
  logic           done;
  logic [IDW-1:0] done_id;
  logic [2*W-1:0] prod;
  modport master (output req, a_in, b_in, input ack, busy, done, done_id, prod);
  modport slave (input req, a_in, b_in, output ack, busy, done, done_id, prod);
endinterface

// File: rtl/mult_dp.sv
// mult_dp: shift-add multiplier datapath; one partial-product step per cycle.
module mult_dp import mult_pkg::*; #(parameter int W = MULT_W) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           zero,
  input  logic           step,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);
  logic [W-1:0] a_r;
  logic [W:0]   sum;
  // Carry bit of the upper-half add shifts straight into the product MSB.
  assign sum = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, a_r} : '0);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_r <= '0;
      p   <= '0;
    end else if (load) begin
      a_r <= a;
      p   <= zero ? '0 : {{W{1'b0}}, b};
    end else if (step) begin
      p <= {sum, p[W-1:1]};
    end
endmodule

// File: rtl/mult_sched.sv
// mult_sched: round-robin arbiter sharing one shift-add multiplier between N requesters.
module mult_sched import mult_pkg::*; #(parameter int W = MULT_W, parameter int N = 2, parameter int IDW = 1) (
  input logic        clk,
  input logic        rst,
  mult_sched_if.slave bus
);
  localparam int CW = clog2(W);
  localparam int SW = IDW + 1;
  if (IDW != clog2(N)) begin : g_idw_check
    $error("IDW must equal clog2(N)");
  end
  state_t         state;
  logic [CW-1:0]  count;
  logic [IDW-1:0] rr_ptr, cur_id, win, idx;
  logic [SW-1:0]  pos;
  logic [N-1:0]   ack_r;
  logic           done_r;
  logic [IDW-1:0] done_id_r;
  logic [2*W-1:0] prod_r, p;
  logic [W-1:0]   a_arr [N];
  logic [W-1:0]   b_arr [N];
  logic           load, zero;
  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign a_arr[i] = bus.a_in[i*W +: W];
    assign b_arr[i] = bus.b_in[i*W +: W];
  end
  // Scan backwards so the requester closest to rr_ptr is the last one written.
  always_comb begin
    win = rr_ptr;
    idx = '0;
    pos = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = {1'b0, rr_ptr} + SW'(k);
      idx = pos >= SW'(N) ? IDW'(pos - SW'(N)) : pos[IDW-1:0];
      if (bus.req[idx]) win = idx;
    end
  end
  assign load = state == IDLE && |bus.req;
  assign zero = a_arr[win] == '0 || b_arr[win] == '0;
  mult_dp #(.W(W)) u_dp (
    .clk (clk),
    .rst (rst),
    .load(load),
    .zero(zero),
    .step(state == RUN),
    .a   (a_arr[win]),
    .b   (b_arr[win]),
    .p   (p)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      rr_ptr    <= '0;
      cur_id    <= '0;
      ack_r     <= '0;
      done_r    <= 1'b0;
      done_id_r <= '0;
      prod_r    <= '0;
    end else begin
      ack_r  <= '0;
      done_r <= 1'b0;
      case (state)
        IDLE: if (load) begin
          ack_r  <= N'(1) << win;
          cur_id <= win;
          count  <= CW'(W - 1);
          state  <= zero ? DONE : RUN;
        end
        RUN: begin
          count <= count - 1'b1;
          if (count == '0) state <= DONE;
        end
        DONE: begin
          done_r    <= 1'b1;
          done_id_r <= cur_id;
          prod_r    <= p;
          rr_ptr    <= cur_id == IDW'(N - 1) ? '0 : cur_id + 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  assign bus.ack     = ack_r;
  assign bus.busy    = state != IDLE;
  assign bus.done    = done_r;
  assign bus.done_id = done_id_r;
  assign bus.prod    = prod_r;
endmodule

// File: tb/tb_mult_sched.sv
// tb_mult_sched: directed and randomized checks of mult_sched against a round-robin product model.
module tb_mult_sched;
  localparam int W = 16;
  localparam int N = 2;
  localparam int IDW = 1;
  logic clk, rst;
  int n_cmp = 0;
  int n_err = 0;
  int model_ptr = 0;
  mult_sched_if #(.W(W), .N(N), .IDW(IDW)) bus ();
  mult_sched #(.W(W), .N(N), .IDW(IDW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    bus.req = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_ptr = 0;
  endtask
  // Serve every requester in mask; model predicts grant order, product and latency.
  task automatic serve(input logic [N-1:0] mask, input logic [W-1:0] av [N], input logic [W-1:0] bv [N]);
    logic [N-1:0] pend, exp_ack;
    logic [2*W-1:0] exp_p;
    int w, c, lat;
    bit got, stray;
    pend = mask;
    for (int i = 0; i < N; i++) begin
      bus.a_in[i*W +: W] = av[i];
      bus.b_in[i*W +: W] = bv[i];
    end
    bus.req = mask;
    while (pend != '0) begin
      w = 0;
      for (int k = N - 1; k >= 0; k--) if (pend[(model_ptr + k) % N]) w = (model_ptr + k) % N;
      exp_ack = '0;
      exp_ack[w] = 1'b1;
      got = 0;
      c = 0;
      while (!got && c < 50) begin
        tick();
        c++;
        got = bus.ack != '0;
      end
      n_cmp++;
      if (bus.ack !== exp_ack) begin
        n_err++;
        $display("FAIL grant: ack=%b expected=%b", bus.ack, exp_ack);
      end
      if (!got) break;
      bus.req[w] = 1'b0;
      pend[w] = 1'b0;
      exp_p = {{W{1'b0}}, av[w]} * {{W{1'b0}}, bv[w]};
      lat = (av[w] == '0 || bv[w] == '0) ? 1 : W + 1;
      bus.a_in[w*W +: W] = W'($urandom);
      bus.b_in[w*W +: W] = W'($urandom);
      n_cmp++;
      if (bus.busy !== 1'b1) begin
        n_err++;
        $display("FAIL busy_at_ack: busy=%b expected=1", bus.busy);
      end
      got = 0;
      stray = 0;
      c = 0;
      while (!got && c < 60) begin
        tick();
        c++;
        got = bus.done === 1'b1;
        if (bus.ack != '0) stray = 1;
      end
      n_cmp++;
      if (c != lat) begin
        n_err++;
        $display("FAIL latency: done after %0d cycles expected %0d", c, lat);
      end
      n_cmp++;
      if (bus.prod !== exp_p) begin
        n_err++;
        $display("FAIL prod: got %h expected %h (id %0d)", bus.prod, exp_p, w);
      end
      n_cmp++;
      if (bus.done_id !== IDW'(w)) begin
        n_err++;
        $display("FAIL done_id: got %0d expected %0d", bus.done_id, w);
      end
      n_cmp++;
      if (stray || bus.busy !== 1'b0) begin
        n_err++;
        $display("FAIL quiet_run: stray_ack=%0d busy_at_done=%b expected 0/0", stray, bus.busy);
      end
      model_ptr = (w + 1) % N;
    end
  endtask
  task automatic test_reset();
    bus.req = '0;
    bus.a_in = '0;
    bus.b_in = '0;
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (bus.ack !== '0) begin n_err++; $display("FAIL reset_ack: got %b expected 0", bus.ack); end
    n_cmp++;
    if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_cmp++;
    if (bus.done_id !== '0) begin n_err++; $display("FAIL reset_done_id: got %b expected 0", bus.done_id); end
    n_cmp++;
    if (bus.prod !== '0) begin n_err++; $display("FAIL reset_prod: got %h expected 0", bus.prod); end
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    rst = 1'b0;
    model_ptr = 0;
  endtask
  task automatic test_single();
    logic [W-1:0] av [N], bv [N];
    av[0] = 16'd3; bv[0] = 16'd5; av[1] = '0; bv[1] = '0;
    serve(2'b01, av, bv);
  endtask
  task automatic test_max();
    logic [W-1:0] av [N], bv [N];
    av[0] = '0; bv[0] = '0; av[1] = 16'hFFFF; bv[1] = 16'hFFFF;
    serve(2'b10, av, bv);
  endtask
  task automatic test_zero();
    logic [W-1:0] av [N], bv [N];
    av[0] = 16'h1234; bv[0] = '0; av[1] = '0; bv[1] = '0;
    serve(2'b01, av, bv);
  endtask
  task automatic test_back_to_back();
    int ack_id [3], ack_t [3], done_id [3];
    logic [2*W-1:0] done_p [3];
    int exp_id [3], na, nd, t;
    logic [2*W-1:0] exp_p [3];
    exp_id = '{0, 1, 0};
    exp_p = '{32'h0E, 32'h51, 32'h0E};
    for (int i = 0; i < 3; i++) begin ack_id[i] = -1; ack_t[i] = -1; done_id[i] = -1; done_p[i] = 'x; end
    bus.a_in = {16'd9, 16'd2};
    bus.b_in = {16'd9, 16'd7};
    rst = 1'b1;
    bus.req = 2'b11;
    tick();
    rst = 1'b0;
    na = 0;
    nd = 0;
    t = 0;
    while (nd < 3 && t < 200) begin
      tick();
      t++;
      if (bus.ack != '0 && na < 3) begin
        ack_id[na] = bus.ack[1] ? 1 : 0;
        ack_t[na] = t;
        na++;
        if (na == 3) bus.req = '0;
      end
      if (bus.done === 1'b1) begin
        done_id[nd] = int'(bus.done_id);
        done_p[nd] = bus.prod;
        nd++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (ack_id[i] != exp_id[i]) begin n_err++; $display("FAIL rr_grant%0d: got %0d expected %0d", i, ack_id[i], exp_id[i]); end
      n_cmp++;
      if (done_id[i] != exp_id[i] || done_p[i] !== exp_p[i]) begin
        n_err++;
        $display("FAIL rr_result%0d: got id %0d prod %h expected id %0d prod %h", i, done_id[i], done_p[i], exp_id[i], exp_p[i]);
      end
    end
    n_cmp++;
    if (ack_t[1] - ack_t[0] != W + 2) begin n_err++; $display("FAIL throughput: grant spacing %0d expected %0d", ack_t[1] - ack_t[0], W + 2); end
    model_ptr = 1;
  endtask
  task automatic test_midrun_reset();
    logic [W-1:0] av [N], bv [N];
    int c, nd;
    bus.a_in[0 +: W] = 16'h00FF;
    bus.b_in[0 +: W] = 16'h0101;
    bus.req = 2'b01;
    c = 0;
    while (bus.ack == '0 && c < 50) begin tick(); c++; end
    bus.req = '0;
    repeat (8) tick();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.ack !== '0 || bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.prod !== '0 || bus.done_id !== '0) begin
      n_err++;
      $display("FAIL async_reset: ack=%b done=%b busy=%b prod=%h id=%b expected all 0", bus.ack, bus.done, bus.busy, bus.prod, bus.done_id);
    end
    tick();
    tick();
    rst = 1'b0;
    model_ptr = 0;
    nd = 0;
    repeat (25) begin tick(); if (bus.done !== 1'b0) nd++; end
    n_cmp++;
    if (nd != 0) begin n_err++; $display("FAIL aborted_done: %0d done pulses expected 0", nd); end
    av[0] = 16'd6; bv[0] = 16'd7; av[1] = '0; bv[1] = '0;
    serve(2'b01, av, bv);
  endtask
  task automatic test_random();
    logic [W-1:0] av [N], bv [N];
    logic [N-1:0] mask;
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < N; i++) begin
        av[i] = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
        bv[i] = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      end
      mask = N'($urandom_range(1, (1 << N) - 1));
      serve(mask, av, bv);
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_max();
    test_zero();
    test_back_to_back();
    test_midrun_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
